// File: rtl/pipe_share_arb_pkg.sv
// Shared types and defaults for pipe_share_arbiter and its round-robin grant core.
package pipe_share_arb_pkg;

  localparam int unsigned DEF_N_REQ   = 4;
  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_LATENCY = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_share_arb_rr.sv
// Round-robin one-hot grant with a rotating priority pointer; the pointer moves past
// the granted requester after every grant and holds otherwise.
module pipe_share_arb_rr
  import pipe_share_arb_pkg::*;
#(
  parameter int unsigned n_req = DEF_N_REQ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [n_req-1:0] req,
  output logic [n_req-1:0] grant
);

  localparam int unsigned PW = ptr_w(n_req);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic          w_hit;

  // Two passes: first requesters at/above the pointer, then the wrapped-around ones.
  always_comb begin
    grant = '0;
    w_idx = '0;
    w_hit = 1'b0;
    if (en) begin
      for (int unsigned i = 0; i < n_req; i++) begin
        if (!w_hit && req[i] && (i >= 32'(r_ptr))) begin
          w_hit = 1'b1;
          w_idx = PW'(i);
        end
      end
      for (int unsigned i = 0; i < n_req; i++) begin
        if (!w_hit && req[i]) begin
          w_hit = 1'b1;
          w_idx = PW'(i);
        end
      end
      if (w_hit) grant[w_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_hit) begin
      r_ptr <= (32'(w_idx) == n_req - 1) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_share_arbiter.sv
// Shares one fixed-latency pipeline among n_req requesters; a tag shift register routes
// results back. Optional checker: define PIPE_SHARE_ARB_CHECK_EN for err_mismatch.
module pipe_share_arbiter
  import pipe_share_arb_pkg::*;
#(
  parameter int unsigned n_req   = DEF_N_REQ,
  parameter int unsigned width   = DEF_WIDTH,
  parameter int unsigned latency = DEF_LATENCY
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [n_req-1:0]       req_vld,
  input  logic [n_req*width-1:0] req_data,
  output logic [n_req-1:0]       req_rdy,
  output logic                   pipe_in_vld,
  output logic [width-1:0]       pipe_in_data,
  input  logic                   pipe_out_vld,
  input  logic [width-1:0]       pipe_out_data,
  output logic [n_req-1:0]       resp_vld,
  output logic [width-1:0]       resp_data,
  input  logic                   drain_req,
  output logic                   drain_done
`ifdef PIPE_SHARE_ARB_CHECK_EN
  ,
  output logic                   err_mismatch
`endif
);

  localparam int unsigned IDW = ptr_w(n_req);
  localparam int unsigned IFW = $clog2(latency + 1);

  state_t           r_state;
  logic             r_drain_done;
  logic [latency-1:0] r_tag_vld;
  logic [IDW-1:0]   r_tag_id [latency];
  logic [IFW-1:0]   r_inflight;
  logic [IFW-1:0]   w_inflight_nxt;
  logic             w_run_en;
  logic             w_issue;
  logic [IDW-1:0]   w_issue_id;
  logic [width-1:0] w_issue_data;
  logic             w_tag_last;

  assign w_run_en = (r_state == ST_RUN);

  pipe_share_arb_rr #(.n_req(n_req)) u_rr (
    .clk   (clk),
    .rst   (rst),
    .en    (w_run_en),
    .req   (req_vld),
    .grant (req_rdy)
  );

  always_comb begin
    w_issue_id   = '0;
    w_issue_data = '0;
    for (int unsigned i = 0; i < n_req; i++) begin
      if (req_rdy[i]) begin
        w_issue_id   = IDW'(i);
        w_issue_data = req_data[i*width +: width];
      end
    end
  end

  assign w_issue      = |(req_vld & req_rdy);
  assign pipe_in_vld  = w_issue;
  assign pipe_in_data = w_issue_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag_vld <= '0;
      for (int unsigned k = 0; k < latency; k++) r_tag_id[k] <= '0;
    end else begin
      r_tag_vld   <= {r_tag_vld[latency-2:0], w_issue};
      r_tag_id[0] <= w_issue_id;
      for (int unsigned k = 1; k < latency; k++) r_tag_id[k] <= r_tag_id[k-1];
    end
  end

  assign w_tag_last = r_tag_vld[latency-1];

  // Invalid tags mask any stale pipe_out_vld, e.g. right after a mid-flight reset.
  always_comb begin
    resp_vld = '0;
    if (pipe_out_vld && w_tag_last) resp_vld[r_tag_id[latency-1]] = 1'b1;
  end

  assign resp_data = pipe_out_data;

  always_comb begin
    case ({w_issue, w_tag_last})
      2'b10:   w_inflight_nxt = r_inflight + IFW'(1);
      2'b01:   w_inflight_nxt = r_inflight - IFW'(1);
      default: w_inflight_nxt = r_inflight;
    endcase
  end

  // DRAIN looks at the next inflight count so drain_done rises right after the last response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_RUN;
      r_drain_done <= 1'b0;
      r_inflight   <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      case (r_state)
        ST_RUN: if (drain_req) r_state <= ST_DRAIN;
        ST_DRAIN: begin
          if (!drain_req) begin
            r_state <= ST_RUN;
          end else if (w_inflight_nxt == '0) begin
            r_state      <= ST_DONE;
            r_drain_done <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!drain_req) begin
            r_state      <= ST_RUN;
            r_drain_done <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_RUN;
          r_drain_done <= 1'b0;
        end
      endcase
    end
  end

  assign drain_done = r_drain_done;

`ifdef PIPE_SHARE_ARB_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else if (pipe_out_vld != w_tag_last) r_err <= 1'b1;
  end

  assign err_mismatch = r_err;

  a_rdy_onehot0: assert property (@(posedge clk) disable iff (!rst) $onehot0(req_rdy));
  a_inflight_max: assert property (@(posedge clk) disable iff (!rst) r_inflight <= IFW'(latency));
`endif

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Bench for pipe_share_arbiter: directed scenarios plus random traffic against a
// queue-based reference model; an external L-cycle pipeline model is attached.
module tb_pipe_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int L = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_vld = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_rdy;
  logic           pipe_in_vld;
  logic [W-1:0]   pipe_in_data;
  logic           pipe_out_vld;
  logic [W-1:0]   pipe_out_data;
  logic [N-1:0]   resp_vld;
  logic [W-1:0]   resp_data;
  logic           drain_req = 1'b0;
  logic           drain_done;
`ifdef PIPE_SHARE_ARB_CHECK_EN
  logic           err_mismatch;
`endif

  pipe_share_arbiter #(.n_req(N), .width(W), .latency(L)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_vld       (req_vld),
    .req_data      (req_data),
    .req_rdy       (req_rdy),
    .pipe_in_vld   (pipe_in_vld),
    .pipe_in_data  (pipe_in_data),
    .pipe_out_vld  (pipe_out_vld),
    .pipe_out_data (pipe_out_data),
    .resp_vld      (resp_vld),
    .resp_data     (resp_data),
    .drain_req     (drain_req),
    .drain_done    (drain_done)
`ifdef PIPE_SHARE_ARB_CHECK_EN
    ,
    .err_mismatch  (err_mismatch)
`endif
  );

  always #5 clk = ~clk;

  // Attached pipeline: L-cycle delay that also transforms the data; not reset by rst.
  logic         pv [L];
  logic [W-1:0] pd [L];
  logic         inj = 1'b0;

  initial begin
    for (int k = 0; k < L; k++) begin
      pv[k] = 1'b0;
      pd[k] = '0;
    end
  end

  always @(posedge clk) begin
    for (int k = L - 1; k > 0; k--) begin
      pv[k] <= pv[k-1];
      pd[k] <= pd[k-1];
    end
    pv[0] <= pipe_in_vld;
    pd[0] <= pipe_in_data ^ 8'hA5;
  end

  assign pipe_out_vld  = pv[L-1] | inj;
  assign pipe_out_data = pd[L-1];

  typedef struct {
    int           due;
    int           id;
    logic [W-1:0] data;
  } exp_t;

  exp_t q[$];
  int   m_ptr   = 0;
  int   m_state = 0;  // 0 RUN, 1 DRAIN, 2 DONE
  bit   m_err   = 1'b0;
  int   cyc     = 0;
  int   ntests  = 0;
  int   nfail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    logic [N-1:0] eg;
    logic [W-1:0] ed;
    logic [N-1:0] er;
    logic [W-1:0] erd;
    int           gi;
    bit           hit;
    @(negedge clk);
    eg = '0; ed = '0; er = '0; erd = '0; gi = -1; hit = 1'b0;
    if (rst && m_state == 0)
      for (int k = 0; k < N; k++)
        if (gi < 0 && req_vld[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
    if (gi >= 0) begin
      eg[gi] = 1'b1;
      ed     = req_data[gi*W +: W];
    end
    foreach (q[j]) if (q[j].due == cyc) begin
      er[q[j].id] = 1'b1;
      erd = q[j].data;
      hit = 1'b1;
    end
    chk("req_rdy", 32'(req_rdy), 32'(eg));
    chk("pipe_in_vld", 32'(pipe_in_vld), 32'(gi >= 0));
    if (gi >= 0) chk("pipe_in_data", 32'(pipe_in_data), 32'(ed));
    chk("resp_vld", 32'(resp_vld), 32'(er));
    if (hit) chk("resp_data", 32'(resp_data), 32'(erd));
    chk("drain_done", 32'(drain_done), 32'(m_state == 2));
`ifdef PIPE_SHARE_ARB_CHECK_EN
    chk("err_mismatch", 32'(err_mismatch), 32'(m_err));
    if (rst && (pipe_out_vld !== hit)) m_err = 1'b1;
`endif
    if (rst) begin
      if (gi >= 0) begin
        q.push_back('{cyc + L, gi, ed ^ 8'hA5});
        m_ptr = (gi + 1) % N;
      end
      for (int j = q.size() - 1; j >= 0; j--) if (q[j].due == cyc) q.delete(j);
      case (m_state)
        0: if (drain_req) m_state = 1;
        1: if (!drain_req) m_state = 0; else if (q.size() == 0) m_state = 2;
        2: if (!drain_req) m_state = 0;
        default: m_state = 0;
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    req_vld   = '0;
    drain_req = 1'b0;
    rst       = 1'b0;
    q.delete();
    m_ptr   = 0;
    m_state = 0;
    m_err   = 1'b0;
    repeat (n) step();
    rst = 1'b1;
  endtask

  task automatic run(input logic [N-1:0] v, input int n);
    req_vld = v;
    repeat (n) step();
  endtask

  initial begin
    #1;
    do_reset(2);

    // Single requester 2 with 0x5A, then watch its response return.
    req_data = '0;
    req_data[2*W +: W] = 8'h5A;
    run(4'b0100, 1);
    run(4'b0000, L + 1);

    // All four continuously: rotating grants, in-order responses.
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(8'h10 + i);
    run(4'b1111, 8);
    run(4'b0000, L);

    // Requesters 1 and 3 alternate.
    run(4'b1010, 8);
    // Single requester held: full throughput.
    run(4'b0001, 6);
    run(4'b0000, L);

    // Three transfers, then drain until done, then resume.
    run(4'b0001, 3);
    req_vld   = '0;
    drain_req = 1'b1;
    repeat (L + 3) step();
    drain_req = 1'b0;
    run(4'b0110, 3);
    run(4'b0000, L + 1);

    // Drain requested in the same cycle as an issue.
    req_vld   = 4'b1000;
    drain_req = 1'b1;
    step();
    req_vld   = 4'b1111;
    repeat (L + 2) step();
    drain_req = 1'b0;
    run(4'b0000, L + 1);

    // Reset with five in flight; stale pipeline outputs must stay masked.
    run(4'b1111, 5);
    run(4'b0000, 2);
    do_reset(2);
    run(4'b0000, L + 2);
    drain_req = 1'b1;
    repeat (3) step();
    drain_req = 1'b0;
    run(4'b1111, 3);
    run(4'b0000, L + 1);

    // Random traffic with occasional drains and one mid-stream reset.
    for (int c = 0; c < 400; c++) begin
      req_vld  = N'($urandom);
      req_data = {$urandom};
      if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
      step();
      if (c == 200) do_reset(2);
    end
    drain_req = 1'b0;
    run(4'b0000, L + 2);

`ifdef PIPE_SHARE_ARB_CHECK_EN
    do_reset(2);
    run(4'b0000, 2);
    inj = 1'b1;
    step();
    inj = 1'b0;
    run(4'b0000, 4);
    do_reset(2);
    run(4'b0000, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
